pulse_stretcher: RTL and testbench

- Converts single-cycle ticks, such as those from the rising-edge detector, back into a level.
- Each accepted tick drives `level` high for a programmable number of cycles.
- A programmable low guard gap follows each high interval.
- Supports optional retrigger, a one-deep pending queue and a saturating dropped-tick counter.
- Sits between tick producers (edge detectors, timers) and slow consumers such as LEDs, external strobes or handshake lines.

---
 rtl/pulse_stretcher.sv | 122 ++++++++++++
 tb/tb_pulse_stretcher.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle ticks into a high level of HIGH_CYCLES cycles, then forces a low guard gap.
// Ticks arriving while busy are retriggered, queued one-deep, or counted as dropped.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8,
    parameter int RETRIGGER   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       clr_drop,
    output logic       level,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HIGH = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pending, pending_n;
    logic             drop_ev;
    logic [7:0]       drop_n;
    logic             serve;
    logic             cnt_zero;

    assign serve    = pending | tick;
    assign cnt_zero = (cnt == '0);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pending_n = pending;
        drop_ev   = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_n = HIGH;
                    cnt_n   = HIGH_LOAD;
                end
            end
            HIGH: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - CNT_ONE;
                    if (tick) begin
                        if (RETRIGGER != 0) cnt_n = HIGH_LOAD;
                        else if (!pending)  pending_n = 1'b1;
                        else                drop_ev = 1'b1;
                    end
                end else if ((RETRIGGER != 0) && tick) begin
                    cnt_n = HIGH_LOAD;
                end else if (GAP_CYCLES > 0) begin
                    state_n = GAP;
                    cnt_n   = GAP_LOAD;
                    if (tick) begin
                        if (!pending) pending_n = 1'b1;
                        else          drop_ev = 1'b1;
                    end
                end else if (serve) begin
                    // No guard gap: back-to-back pulses merge into one continuous level.
                    cnt_n     = HIGH_LOAD;
                    pending_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            GAP: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - CNT_ONE;
                    if (tick) begin
                        if (!pending) pending_n = 1'b1;
                        else          drop_ev = 1'b1;
                    end
                end else if (serve) begin
                    state_n   = HIGH;
                    cnt_n     = HIGH_LOAD;
                    pending_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n   = IDLE;
                cnt_n     = '0;
                pending_n = 1'b0;
            end
        endcase
    end

    // Clear has priority over a coincident drop; the count saturates rather than wraps.
    always_comb begin
        drop_n = drop_cnt;
        if (clr_drop)                          drop_n = 8'd0;
        else if (drop_ev && drop_cnt != 8'hFF) drop_n = drop_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pending  <= 1'b0;
            level    <= 1'b0;
            busy     <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pending  <= pending_n;
            level    <= (state_n == HIGH);
            busy     <= (state_n != IDLE) | pending_n;
            drop_cnt <= drop_n;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench: three stretcher configurations driven from cycle-indexed stimulus tables,
// with expected level/busy per cycle queued as ticks are driven and compared as outputs appear.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_v = 1'b0;
    logic       clr_v = 1'b0;
    int         sel = 0;

    logic       tick_a, tick_b, tick_c;
    logic       clr_a, clr_b, clr_c;
    logic       level_a, level_b, level_c;
    logic       busy_a, busy_b, busy_c;
    logic [7:0] drop_a, drop_b, drop_c;

    logic       level_s, busy_s;
    logic [7:0] drop_s;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    assign tick_a = (sel == 0) & tick_v;
    assign tick_b = (sel == 1) & tick_v;
    assign tick_c = (sel == 2) & tick_v;
    assign clr_a  = (sel == 0) & clr_v;
    assign clr_b  = (sel == 1) & clr_v;
    assign clr_c  = (sel == 2) & clr_v;

    always_comb begin
        level_s = level_a;
        busy_s  = busy_a;
        drop_s  = drop_a;
        case (sel)
            1: begin level_s = level_b; busy_s = busy_b; drop_s = drop_b; end
            2: begin level_s = level_c; busy_s = busy_c; drop_s = drop_c; end
            default: ;
        endcase
    end

    // a: queued mode with gap; b: retrigger with gap; c: queued mode without gap
    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8), .RETRIGGER(0)) u_a (
        .clk(clk), .reset(reset), .tick(tick_a), .clr_drop(clr_a),
        .level(level_a), .busy(busy_a), .drop_cnt(drop_a));
    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8), .RETRIGGER(1)) u_b (
        .clk(clk), .reset(reset), .tick(tick_b), .clr_drop(clr_b),
        .level(level_b), .busy(busy_b), .drop_cnt(drop_b));
    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8), .RETRIGGER(0)) u_c (
        .clk(clk), .reset(reset), .tick(tick_c), .clr_drop(clr_c),
        .level(level_c), .busy(busy_c), .drop_cnt(drop_c));

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bit c of each mask is the tick driven / value expected during cycle c.
    task automatic run_seq(input string name, input logic [31:0] ticks,
                           input logic [31:0] lvl_m, input logic [31:0] busy_m,
                           input int ncyc);
        logic [1:0] e;
        exp_q.push_back({lvl_m[0], busy_m[0]});
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("%s_c%0d_level", name, c), {7'd0, level_s}, {7'd0, e[1]});
            check($sformatf("%s_c%0d_busy", name, c), {7'd0, busy_s}, {7'd0, e[0]});
            tick_v = ticks[c];
            exp_q.push_back({lvl_m[c+1], busy_m[c+1]});
        end
        @(negedge clk);
        tick_v = 1'b0;
        e = exp_q.pop_front();
        check($sformatf("%s_c%0d_level", name, ncyc), {7'd0, level_s}, {7'd0, e[1]});
        check($sformatf("%s_c%0d_busy", name, ncyc), {7'd0, busy_s}, {7'd0, e[0]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("rst_level_a", {7'd0, level_a}, 8'd0);
        check("rst_busy_a", {7'd0, busy_a}, 8'd0);
        check("rst_drop_a", drop_a, 8'd0);
        check("rst_level_b", {7'd0, level_b}, 8'd0);
        check("rst_busy_c", {7'd0, busy_c}, 8'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // single tick: high cycles 1-4, gap 5-6, idle from 7
        sel = 0;
        run_seq("single", 32'h1, 32'h1E, 32'h7E, 10);
        check("single_drop", drop_s, 8'd0);

        // ticks at 0,2,3: cycle 2 queued, cycle 3 dropped
        run_seq("queue", 32'hD, 32'h79E, 32'h1FFE, 15);
        check("queue_drop", drop_s, 8'd1);

        // retrigger at cycle 3 extends the high interval to cycle 7
        sel = 1;
        run_seq("retrig", 32'h9, 32'hFE, 32'h3FE, 12);
        check("retrig_drop", drop_s, 8'd0);

        // no gap: tick on terminal cycle merges the two pulses
        sel = 2;
        run_seq("nogap", 32'h11, 32'h1FE, 32'h1FE, 12);
        check("nogap_drop", drop_s, 8'd0);

        // held tick saturates drop_cnt; clear over three cycles covers a coincident drop
        sel = 0;
        tick_v = 1'b1;
        for (int c = 0; c < 450; c++) begin
            @(negedge clk);
            if (c == 420) check("sat_drop_420", drop_s, 8'd255);
        end
        check("sat_drop_450", drop_s, 8'd255);
        clr_v = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("clr_drop_%0d", c), drop_s, 8'd0);
        end
        clr_v  = 1'b0;
        tick_v = 1'b0;
        repeat (20) @(negedge clk);
        check("drain_busy", {7'd0, busy_s}, 8'd0);
        check("drain_level", {7'd0, level_s}, 8'd0);

        // reset during gap with a pending tick
        for (int c = 0; c < 5; c++) begin
            tick_v = (c == 0 || c == 2 || c == 3);
            @(negedge clk);
        end
        tick_v = 1'b0;
        check("pre_rst_level", {7'd0, level_s}, 8'd0);
        check("pre_rst_busy", {7'd0, busy_s}, 8'd1);
        check("pre_rst_drop", drop_s, 8'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_level", {7'd0, level_s}, 8'd0);
        check("async_rst_busy", {7'd0, busy_s}, 8'd0);
        check("async_rst_drop", drop_s, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        run_seq("post_rst", 32'h0, 32'h0, 32'h0, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
